// File: rtl/regfile_wb_scheduler.sv
// rtl/regfile_wb_scheduler.sv - register file write-port arbiter and busy scoreboard; optional SCOREBOARD_BYPASS_EN
module regfile_wb_scheduler #(
    parameter int REGISTER_WIDTH = 5,
    parameter int DATA_WIDTH     = 64,
    parameter int NUM_REGS       = 32
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      issue_valid,
    input  logic [REGISTER_WIDTH-1:0] issue_rd,
    input  logic                      issue_rd_we,
    input  logic [REGISTER_WIDTH-1:0] issue_rs1,
    input  logic [REGISTER_WIDTH-1:0] issue_rs2,
    output logic                      issue_ready,
    input  logic                      alu_wb_valid,
    input  logic [REGISTER_WIDTH-1:0] alu_wb_rd,
    input  logic [DATA_WIDTH-1:0]     alu_wb_data,
    output logic                      alu_wb_ready,
    input  logic                      mem_wb_valid,
    input  logic [REGISTER_WIDTH-1:0] mem_wb_rd,
    input  logic [DATA_WIDTH-1:0]     mem_wb_data,
    output logic                      mem_wb_ready,
    output logic                      rf_we,
    output logic [REGISTER_WIDTH-1:0] rf_waddr,
    output logic [DATA_WIDTH-1:0]     rf_wdata,
    output logic [NUM_REGS-1:0]       busy_mask
);

    logic                      last_grant;
    logic [NUM_REGS-1:0]       busy_q;
    logic                      grant_alu;
    logic                      grant_mem;
    logic                      wb_fire;
    logic                      wb_write;
    logic [REGISTER_WIDTH-1:0] wb_rd;
    logic [DATA_WIDTH-1:0]     wb_data;
    logic [NUM_REGS-1:0]       clear_mask;
    logic [NUM_REGS-1:0]       set_mask;
    logic [NUM_REGS-1:0]       issue_busy;
    logic [NUM_REGS-1:0]       busy_next;
    logic                      issue_fire;

    // last_grant = 1 means MEM won last, so ALU wins the next contention
    always_comb begin
        grant_alu = alu_wb_valid && (!mem_wb_valid || last_grant);
        grant_mem = mem_wb_valid && (!alu_wb_valid || !last_grant);
        wb_fire   = grant_alu || grant_mem;
        wb_rd     = grant_alu ? alu_wb_rd : mem_wb_rd;
        wb_data   = grant_alu ? alu_wb_data : mem_wb_data;
        wb_write  = wb_fire && (wb_rd != '0);
    end

    assign alu_wb_ready = grant_alu;
    assign mem_wb_ready = grant_mem;

    always_comb begin
        clear_mask = '0;
        if (wb_write) begin
            clear_mask = NUM_REGS'(1) << wb_rd;
        end
`ifdef SCOREBOARD_BYPASS_EN
        issue_busy = busy_q & ~clear_mask;
`else
        issue_busy = busy_q;
`endif
        issue_ready = !(issue_busy[issue_rs1] || issue_busy[issue_rs2] ||
                        (issue_rd_we && issue_busy[issue_rd]));
        issue_fire = issue_valid && issue_ready;
        set_mask = '0;
        if (issue_fire && issue_rd_we && (issue_rd != '0)) begin
            set_mask = NUM_REGS'(1) << issue_rd;
        end
        // set is applied after clear so a same-cycle re-issue keeps the bit
        busy_next    = (busy_q & ~clear_mask) | set_mask;
        busy_next[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            last_grant <= 1'b1;
            busy_q     <= '0;
            rf_we      <= 1'b0;
            rf_waddr   <= '0;
            rf_wdata   <= '0;
        end else begin
            busy_q <= busy_next;
            rf_we  <= wb_write;
            if (wb_fire) begin
                last_grant <= grant_mem;
            end
            if (wb_write) begin
                rf_waddr <= wb_rd;
                rf_wdata <= wb_data;
            end
        end
    end

    assign busy_mask = busy_q;

endmodule

// File: tb/tb_regfile_wb_scheduler.sv
// tb/tb_regfile_wb_scheduler.sv - scoreboard bench for regfile_wb_scheduler
module tb_regfile_wb_scheduler;

    logic        clk = 1'b0;
    logic        reset;
    logic        issue_valid;
    logic [4:0]  issue_rd;
    logic        issue_rd_we;
    logic [4:0]  issue_rs1;
    logic [4:0]  issue_rs2;
    logic        issue_ready;
    logic        alu_wb_valid;
    logic [4:0]  alu_wb_rd;
    logic [63:0] alu_wb_data;
    logic        alu_wb_ready;
    logic        mem_wb_valid;
    logic [4:0]  mem_wb_rd;
    logic [63:0] mem_wb_data;
    logic        mem_wb_ready;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [63:0] rf_wdata;
    logic [31:0] busy_mask;

    int pass_cnt  = 0;
    int total_cnt = 0;
    logic [68:0] exp_q[$];
    bit bypass;

    regfile_wb_scheduler dut (
        .clk(clk), .reset(reset),
        .issue_valid(issue_valid), .issue_rd(issue_rd), .issue_rd_we(issue_rd_we),
        .issue_rs1(issue_rs1), .issue_rs2(issue_rs2), .issue_ready(issue_ready),
        .alu_wb_valid(alu_wb_valid), .alu_wb_rd(alu_wb_rd), .alu_wb_data(alu_wb_data),
        .alu_wb_ready(alu_wb_ready),
        .mem_wb_valid(mem_wb_valid), .mem_wb_rd(mem_wb_rd), .mem_wb_data(mem_wb_data),
        .mem_wb_ready(mem_wb_ready),
        .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata), .busy_mask(busy_mask)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [68:0] act, input logic [68:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    // every register-file write must match the oldest expected write
    always @(negedge clk) begin
        if (rf_we === 1'b1) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_rf_write", {rf_waddr, rf_wdata}, 69'h0);
            end else begin
                chk("rf_write", {rf_waddr, rf_wdata}, exp_q.pop_front());
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        issue_valid = 0; issue_rd = 0; issue_rd_we = 0; issue_rs1 = 0; issue_rs2 = 0;
        alu_wb_valid = 0; alu_wb_rd = 0; alu_wb_data = 0;
        mem_wb_valid = 0; mem_wb_rd = 0; mem_wb_data = 0;
    endtask

    task automatic do_issue(input logic [4:0] rd, input logic we, input logic [4:0] rs1, input logic [4:0] rs2);
        issue_valid = 1; issue_rd = rd; issue_rd_we = we; issue_rs1 = rs1; issue_rs2 = rs2;
    endtask

    initial begin
`ifdef SCOREBOARD_BYPASS_EN
        bypass = 1'b1;
`else
        bypass = 1'b0;
`endif
        idle();
        reset = 1;
        cyc(); cyc();
        @(negedge clk);
        chk("reset_rf_we", rf_we, 0);
        chk("reset_rf_waddr", rf_waddr, 0);
        chk("reset_rf_wdata", rf_wdata, 0);
        chk("reset_busy", busy_mask, 0);
        chk("reset_issue_ready", issue_ready, 1);
        chk("reset_alu_ready", alu_wb_ready, 0);
        chk("reset_mem_ready", mem_wb_ready, 0);
        cyc();
        reset = 0;

        // round-robin: ALU first after reset, then alternate
        alu_wb_valid = 1; alu_wb_rd = 1; alu_wb_data = 64'hA0;
        mem_wb_valid = 1; mem_wb_rd = 2; mem_wb_data = 64'hB0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("rr_alu_ready", alu_wb_ready, (k % 2 == 0));
            chk("rr_mem_ready", mem_wb_ready, (k % 2 == 1));
            if (k % 2 == 0) exp_q.push_back({5'd1, alu_wb_data});
            else            exp_q.push_back({5'd2, mem_wb_data});
            cyc();
            if (k % 2 == 0) alu_wb_data = alu_wb_data + 1;
            else            mem_wb_data = mem_wb_data + 1;
        end
        idle();
        @(negedge clk);
        chk("rr_busy_unchanged", busy_mask, 0);
        cyc();

        // issue rd=5, then a rs1=5 consumer stalls
        do_issue(5, 1, 0, 0);
        @(negedge clk);
        chk("issue_rd5_ready", issue_ready, 1);
        cyc();
        do_issue(6, 1, 5, 0);
        @(negedge clk);
        chk("busy_rd5", busy_mask, 32'h20);
        chk("raw_stall_rs1", issue_ready, 0);
        cyc();
        issue_valid = 0;
        alu_wb_valid = 1; alu_wb_rd = 5; alu_wb_data = 64'h55;
        @(negedge clk);
        chk("wb5_alu_ready", alu_wb_ready, 1);
        exp_q.push_back({5'd5, 64'h55});
        cyc();
        idle();
        @(negedge clk);
        chk("busy_cleared_5", busy_mask, 0);
        cyc();

        // same-cycle writeback and dependent issue on x7
        do_issue(7, 1, 0, 0);
        cyc();
        do_issue(0, 0, 7, 0);
        alu_wb_valid = 1; alu_wb_rd = 7; alu_wb_data = 64'h77;
        @(negedge clk);
        chk("busy_rd7", busy_mask, 32'h80);
        chk("bypass_same_cycle_ready", issue_ready, bypass);
        exp_q.push_back({5'd7, 64'h77});
        cyc();
        alu_wb_valid = 0;
        @(negedge clk);
        chk("ready_after_wb7", issue_ready, 1);
        chk("busy_after_wb7", busy_mask, 0);
        cyc();
        idle();

        // writeback to x0 is granted and discarded
        alu_wb_valid = 1; alu_wb_rd = 0; alu_wb_data = 64'hDEAD;
        @(negedge clk);
        chk("x0_alu_ready", alu_wb_ready, 1);
        cyc();
        idle();
        @(negedge clk);
        chk("x0_rf_we", rf_we, 0);
        chk("x0_waddr_held", rf_waddr, 7);
        chk("x0_wdata_held", rf_wdata, 64'h77);
        chk("x0_busy", busy_mask, 0);
        cyc();

        // WAW stall on x4 until its writeback
        do_issue(4, 1, 0, 0);
        cyc();
        do_issue(4, 1, 0, 0);
        @(negedge clk);
        chk("waw_busy4", busy_mask, 32'h10);
        chk("waw_stall", issue_ready, 0);
        cyc();
        @(negedge clk);
        chk("waw_stall_hold", issue_ready, 0);
        cyc();
        mem_wb_valid = 1; mem_wb_rd = 4; mem_wb_data = 64'h44;
        @(negedge clk);
        chk("waw_mem_ready", mem_wb_ready, 1);
        chk("waw_wb_cycle_ready", issue_ready, bypass);
        exp_q.push_back({5'd4, 64'h44});
        cyc();
        idle();
        @(negedge clk);
        chk("waw_busy_after", busy_mask, bypass ? 32'h10 : 32'h0);
        cyc();

        // reset mid-operation with busy x3 and a pending MEM request
        do_issue(3, 1, 0, 0);
        cyc();
        idle();
        @(negedge clk);
        chk("busy3_set", busy_mask[3], 1);
        cyc();
        reset = 1;
        mem_wb_valid = 1; mem_wb_rd = 3; mem_wb_data = 64'h33;
        cyc();
        reset = 0;
        idle();
        @(negedge clk);
        chk("mid_reset_busy", busy_mask, 0);
        chk("mid_reset_rf_we", rf_we, 0);
        cyc();
        alu_wb_valid = 1; alu_wb_rd = 1; alu_wb_data = 64'hC1;
        mem_wb_valid = 1; mem_wb_rd = 2; mem_wb_data = 64'hC2;
        @(negedge clk);
        chk("post_reset_alu_ready", alu_wb_ready, 1);
        chk("post_reset_mem_ready", mem_wb_ready, 0);
        exp_q.push_back({5'd1, 64'hC1});
        cyc();
        alu_wb_valid = 0;
        @(negedge clk);
        chk("post_reset_mem_grant", mem_wb_ready, 1);
        exp_q.push_back({5'd2, 64'hC2});
        cyc();
        idle();
        cyc(); cyc();
        chk("queue_drained", exp_q.size(), 0);
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
